// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared state encoding and sizing helpers for the sequential divider
package seq_divider_pkg;

   localparam int DIV_WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

   // Counter must hold the value WIDTH itself, not just WIDTH-1.
   function automatic int div_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/seq_divider_div_trial_sub.sv
// rtl/seq_divider_div_trial_sub.sv - combinational trial subtractor for restoring division
module div_trial_sub #(
   parameter int W = 9
) (
   input  logic [W-1:0] i_minuend,
   input  logic [W-1:0] i_subtrahend,
   output logic [W-1:0] o_diff,
   output logic         o_neg
);

   assign o_diff = i_minuend - i_subtrahend;
   // One guard bit above the operands makes the MSB a reliable borrow flag.
   assign o_neg  = o_diff[W-1];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider with start/done handshake
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_in_a,
   input  logic [WIDTH-1:0] i_in_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_q,
   output logic [WIDTH-1:0] o_r,
   output logic             o_div_by_zero
);

   localparam int CW = div_cnt_width(WIDTH);
   localparam logic [WIDTH-1:0] DIV_ZERO_Q = '1;
   localparam logic [CW-1:0]    LAST_ITER  = CW'(WIDTH - 1);

   div_state_t       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH:0]   r_p;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_r;
   logic             r_dbz;
   logic             r_busy;
   logic             r_done;

   logic [WIDTH:0]   w_shift_p;
   logic [WIDTH:0]   w_diff;
   logic             w_neg;
   logic [WIDTH:0]   w_next_p;
   logic [WIDTH-1:0] w_next_a;

   // The partial remainder always stays below B, so its MSB is zero before the shift.
   assign w_shift_p = {r_p[WIDTH-1:0], r_a[WIDTH-1]};

   div_trial_sub #(.W(WIDTH + 1)) u_trial (
      .i_minuend    (w_shift_p),
      .i_subtrahend ({1'b0, r_b}),
      .o_diff       (w_diff),
      .o_neg        (w_neg)
   );

   assign w_next_p = w_neg ? w_shift_p : w_diff;
   assign w_next_a = {r_a[WIDTH-2:0], ~w_neg};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= DIV_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_p     <= '0;
         r_cnt   <= '0;
         r_q     <= '0;
         r_r     <= '0;
         r_dbz   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         unique case (r_state)
            DIV_IDLE, DIV_DONE: begin
               r_done <= 1'b0;
               if (r_state == DIV_DONE && !i_start) begin
                  r_state <= DIV_IDLE;
               end
               if (i_start) begin
                  if (i_in_b == '0) begin
                     r_state <= DIV_DONE;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_dbz   <= 1'b1;
                     r_q     <= DIV_ZERO_Q;
                     r_r     <= i_in_a;
                  end else begin
                     r_state <= DIV_RUN;
                     r_busy  <= 1'b1;
                     r_a     <= i_in_a;
                     r_b     <= i_in_b;
                     r_p     <= '0;
                     r_cnt   <= '0;
                  end
               end
            end
            DIV_RUN: begin
               r_a   <= w_next_a;
               r_p   <= w_next_p;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST_ITER) begin
                  r_state <= DIV_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_dbz   <= 1'b0;
                  r_q     <= w_next_a;
                  r_r     <= w_next_p[WIDTH-1:0];
               end
            end
            default: begin
               r_state <= DIV_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_q           = r_q;
   assign o_r           = r_r;
   assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed vector table plus corner sequences for seq_divider
module tb_seq_divider;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       busy;
   logic       done;
   logic [7:0] q;
   logic [7:0] r;
   logic       dbz;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(8)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_start       (start),
      .i_in_a        (in_a),
      .i_in_b        (in_b),
      .o_busy        (busy),
      .o_done        (done),
      .o_q           (q),
      .o_r           (r),
      .o_div_by_zero (dbz)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] eq;
      logic [7:0] er;
      logic       edbz;
      int         elat;
   } vec_t;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int busy_cnt);
      @(negedge clk);
      start = 1'b1;
      in_a  = a;
      in_b  = b;
      @(posedge clk);
      #1;
      start    = 1'b0;
      lat      = 0;
      busy_cnt = 0;
      while (!done && lat < 20) begin
         if (busy) busy_cnt++;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   initial begin
      vec_t vecs[7];
      int lat, bcnt, gap;
      logic [7:0] ra, rb;

      vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 8};
      vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 8};
      vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 8};
      vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 8};
      vecs[4] = '{8'd0,   8'd3,   8'd0,   8'd0,  1'b0, 8};
      vecs[5] = '{8'd37,  8'd0,   8'hFF,  8'd37, 1'b1, 0};
      vecs[6] = '{8'd20,  8'd4,   8'd5,   8'd0,  1'b0, 8};

      rst = 1'b1; start = 1'b0; in_a = '0; in_b = '0;
      @(posedge clk); #1;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_q", q, 0);
      chk("reset_r", r, 0);
      chk("reset_dbz", dbz, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].a, vecs[i].b, lat, bcnt);
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].elat);
         chk($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].elat);
         chk($sformatf("vec%0d_busy_at_done", i), busy, 0);
         chk($sformatf("vec%0d_q", i), q, vecs[i].eq);
         chk($sformatf("vec%0d_r", i), r, vecs[i].er);
         chk($sformatf("vec%0d_dbz", i), dbz, vecs[i].edbz);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_done_one_cycle", i), done, 0);
      end

      // Start while busy: 9/9 at edge k+3 must be ignored.
      @(negedge clk);
      start = 1'b1; in_a = 8'd200; in_b = 8'd3;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      repeat (2) begin @(posedge clk); #1; lat++; end
      @(negedge clk);
      start = 1'b1; in_a = 8'd9; in_b = 8'd9;
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
      while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
      chk("busy_start_latency", lat, 8);
      chk("busy_start_q", q, 66);
      chk("busy_start_r", r, 2);

      // Reset at edge k+4 aborts the operation.
      @(negedge clk);
      start = 1'b1; in_a = 8'd200; in_b = 8'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_q", q, 0);
      chk("abort_r", r, 0);
      chk("abort_dbz", dbz, 0);
      @(negedge clk);
      rst = 1'b0;
      gap = 0;
      repeat (12) begin @(posedge clk); #1; if (done || busy) gap++; end
      chk("abort_no_done", gap, 0);
      run_op(8'd50, 8'd6, lat, bcnt);
      chk("after_abort_latency", lat, 8);
      chk("after_abort_q", q, 8);
      chk("after_abort_r", r, 2);

      // Back-to-back with Start held high.
      @(negedge clk);
      start = 1'b1; in_a = 8'd17; in_b = 8'd5;
      @(posedge clk); #1;
      lat = 0;
      while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
      chk("b2b_first_latency", lat, 8);
      chk("b2b_first_q", q, 3);
      chk("b2b_first_r", r, 2);
      in_a = 8'd64; in_b = 8'd8;
      @(posedge clk); #1;
      start = 1'b0;
      gap = 1;
      chk("b2b_busy_after_done", busy, 1);
      while (!done && gap < 20) begin @(posedge clk); #1; gap++; end
      chk("b2b_done_spacing", gap, 9);
      chk("b2b_second_q", q, 8);
      chk("b2b_second_r", r, 0);

      // Random sweep with the division identity checked at every Done.
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(1, 255));
         run_op(ra, rb, lat, bcnt);
         chk($sformatf("rand%0d_%0d_%0d_q", i, ra, rb), q, ra / rb);
         chk($sformatf("rand%0d_%0d_%0d_r", i, ra, rb), r, ra % rb);
         chk($sformatf("rand%0d_invariant", i),
             ((int'(q) * int'(rb) + int'(r)) == int'(ra)) && (r < rb), 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Multi-cycle unsigned integer divider for the RISC CPU datapath. It is the inverse arithmetic unit to the 8-bit adder: it computes quotient and remainder by restoring division, using repeated trial subtraction. The ALU issues an operation with a Start/Done handshake, and the control unit stalls on Busy.

Parameters:
WIDTH, 8, operand/result width in bits (minimum 2).

Ports:
Clk  input  1  system clock; all state updates on rising edge
Rst  input  1  reset, synchronous, active-high; one clock only
Start  input  1  request; sampled only when not Busy
InA  input  WIDTH  dividend, captured on accepted Start
InB  input  WIDTH  divisor, captured on accepted Start
Busy  output  1  iteration in progress
Done  output  1  one-cycle pulse; Q/R/DivByZero valid
Q  output  WIDTH  quotient, held until next accepted Start
R  output  WIDTH  remainder, held until next accepted Start
DivByZero  output  1  set with Done when the captured divisor is 0; held with Q/R

Behaviour:
- Reset: on any rising edge with Rst=1, state goes to IDLE and Busy=0, Done=0, Q=0, R=0, DivByZero=0, counter=0. Rst has priority over Start and aborts a running division; no Done is produced for an aborted operation.
- States: IDLE, RUN, DONE.
  - IDLE: Start=1 and InB!=0 -> RUN. Start=1 and InB==0 -> DONE with DivByZero=1, Q=all-ones, R=InA. Otherwise stay in IDLE.
  - RUN: one iteration per clock. After the WIDTH-th iteration -> DONE.
  - DONE: Done=1 for exactly this cycle. A Start here is accepted (same rules as IDLE), giving back-to-back operation. Without Start -> IDLE.
- Accepted Start, normal case:
  - Capture divisor B; load the dividend shift register A=InA.
  - Clear the partial remainder P (WIDTH+1 bits), set counter=0, DivByZero=0.
- Iteration, each RUN cycle:
  - {P,A} shifts left 1 (MSB of A into P LSB).
  - T = P - {0,B}, computed WIDTH+1 wide.
  - If T is non-negative (T MSB=0): P=T and the shifted-in A LSB=1. Otherwise P is unchanged and the LSB=0.
  - counter+1.
- Result update: on the DONE transition, Q=A and R=P[WIDTH-1:0]. Q/R/DivByZero change only on that transition or on reset.
- Timing: Start sampled at edge k.
  - Normal: Busy=1 from edge k to edge k+WIDTH, Done=1 from edge k+WIDTH to k+WIDTH+1. Latency is WIDTH cycles (8 for default).
  - Divide by zero: Busy stays 0; Done=1 from edge k to k+1.
- Start while Busy: ignored; InA/InB changes have no effect.
- Start held high continuously: a new operation is accepted in every DONE cycle.
- Invariants on Done (non-zero divisor): InA = Q*InB + R and R < InB.
- No signed mode. There is no overflow case beyond divide-by-zero.

Decomposition:
- Shared header cpu_defs.vh holds:
  - the state encoding localparams DIV_IDLE=2'd0, DIV_RUN=2'd1, DIV_DONE=2'd2
  - the divider WIDTH default
  - the divide-by-zero quotient constant (all-ones)
- One sub-module, div_trial_sub:
  - combinational WIDTH+1-bit subtractor with ports Minuend, Subtrahend, Diff, Neg
  - mirrors the adder's structure and keeps the FSM file purely sequential.
- Counter width is clog2(WIDTH+1).

Test Plan:
- 100/7: Start at edge k -> Busy high for 8 cycles, Done pulse at edge k+8, Q=14, R=2, DivByZero=0.
- Boundary operands: 255/1 -> Q=255, R=0. 5/9 -> Q=0, R=5. 255/255 -> Q=1, R=0. 0/3 -> Q=0, R=0.
- Divide by zero, 37/0 -> Done at edge k (one cycle), Busy never high, Q=8'hFF, R=37, DivByZero=1. A following 20/4 clears DivByZero and gives Q=5, R=0.
- Start while Busy: start 200/3, then pulse Start with 9/9 at edge k+3 -> ignored; Done at k+8 with Q=66, R=2.
- Rst mid-operation: Rst at edge k+4 -> all outputs 0, no Done. A fresh Start with 50/6 -> Q=8, R=2 after 8 cycles.
- Back-to-back operation, Start held high with 17/5 then 64/8 -> second op accepted in the DONE cycle. Done pulses 9 cycles apart; results Q=3/R=2, then Q=8/R=0.
- Randomized sweep: 1000 random pairs, with the InA = Q*InB + R, R < InB invariant checked at every Done.
